control_decoder_n: RTL and testbench
====================================

// Module: control_decoder_n
// PURPOSE
//  Parametrised successor to the 4-bit switch control decoder. Takes WIDTH raw slide-switch
//  inputs and does four things before presenting them to the datapath as a control word:
//  synchronises them to clk_div, debounces each bit, and supports a hold (freeze) mode.
//  It also flags which bits changed, with a one-cycle update strobe.
// PARAMETERS
//  WIDTH            4      number of switch/control bits
//  SYNC_STAGES      2      synchroniser flops per bit (legal: >=2)
//  DEBOUNCE_CYCLES  16     consecutive cycles a new level must persist before acceptance (>=1)
//  RESET_VALUE      0      WIDTH-bit value loaded into sync chain, stable reg and ctrl_word at reset
// PORTS
//  clk_div       in   1      system (divided) clock, rising edge
//  BTN0          in   1      asynchronous active-low reset
//  SW            in   WIDTH  raw switch inputs, asynchronous to clk_div
//  hold          in   1      1 = freeze ctrl_word; synchronous, level-sensitive
//  ctrl_word     out  WIDTH  registered, debounced control word
//  ctrl_valid    out  1      one-cycle pulse on every cycle ctrl_word changes value
//  changed_mask  out  WIDTH  one-cycle: old ctrl_word XOR new ctrl_word; 0 otherwise
// BEHAVIOUR
//  - Reset (BTN0=0, async): sync chains and stable = RESET_VALUE; debounce counters = 0;
//    ctrl_word = RESET_VALUE; ctrl_valid = 0; changed_mask = 0. No pulse on reset release.
//  - Sync: per bit, SW passes through SYNC_STAGES flops; sync_out = last stage.
//  - Debounce, per bit i, each edge:
//    - sync_out[i] == stable[i]: cnt[i] <= 0.
//    - mismatch and cnt[i] == DEBOUNCE_CYCLES-1: stable[i] <= sync_out[i], cnt[i] <= 0.
//    - mismatch otherwise: cnt[i] <= cnt[i]+1.
//    - A glitch shorter than DEBOUNCE_CYCLES cycles (at sync_out) never changes stable.
//    - Counters never wrap; width = clog2(DEBOUNCE_CYCLES) (min 1).
//  - Output register, each edge:
//    - hold=0: ctrl_word <= stable.
//    - hold=1: ctrl_word kept. Debounce keeps tracking SW while held.
//    - If the loaded value differs from current ctrl_word: ctrl_valid <= 1,
//      changed_mask <= ctrl_word ^ stable. Otherwise both <= 0 (strictly single-cycle pulses).
//  - Latency: a SW change held steady from before edge 0 appears on ctrl_word at
//    edge SYNC_STAGES+DEBOUNCE_CYCLES+1 (hold=0). ctrl_valid and changed_mask assert the same edge.
//  - Hold release: the first edge with hold=0 loads stable. This pulses once, with the
//    accumulated mask, if any bit differs. Multiple changes while held yield one pulse.
//  - Simultaneous bit changes: independent counters, so bits settle separately. If they
//    settle the same cycle, one pulse with multi-bit mask.
//  - Reset mid-debounce: all progress discarded; outputs go to reset values immediately.
// STRUCTURE
//  - Shared package control_pkg:
//    - CLOG2 function, default WIDTH/SYNC_STAGES/DEBOUNCE_CYCLES constants.
//    - CTRL_RESET_VALUE constant, used by the top level and the bench.
//  - Sub-module debounce_bit: sync chain, counter and stable flop for one bit; instantiated
//    WIDTH times via generate.
//  - Top level holds ctrl_word, hold mux, change detect and strobe registers.
// TESTING  (bench: WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_VALUE=0; latency = 7)
//  1 Reset: BTN0=0 with SW=4'b1111 -> ctrl_word=0, ctrl_valid=0, changed_mask=0 throughout;
//    release BTN0 -> after 7 edges ctrl_word=4'b1111, one-cycle ctrl_valid, changed_mask=4'b1111.
//  2 Latency: SW 0000->0101 steady -> ctrl_word=0101 exactly at edge 7. ctrl_valid high 1 cycle,
//    mask=0101. No further pulses.
//  3 Glitch: SW[3] high for 3 cycles then low -> ctrl_word unchanged, ctrl_valid never asserts.
//    High for 4 cycles -> accepted.
//  4 Hold: hold=1, SW 0101->1010 -> ctrl_word stays 0101 for 20 cycles. hold=0 -> next edge
//    ctrl_word=1010, single pulse, mask=1111.
//  5 Reset mid-debounce: SW change, BTN0=0 at cycle 4 for 2 cycles -> outputs RESET_VALUE
//    immediately. After release, change accepted 7 edges later.
//  6 Staggered bits: SW[0] rises at t, SW[1] at t+2 -> two separate pulses 2 cycles apart,
//    masks 0001 then 0010.

Source files
------------

// File: rtl/control_pkg.sv
// Shared constants and helpers for the switch control decoder.
package control_pkg;

   localparam int unsigned DEF_WIDTH           = 4;
   localparam int unsigned DEF_SYNC_STAGES     = 2;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;

   localparam logic [DEF_WIDTH-1:0] CTRL_RESET_VALUE = '0;

   // Ceiling log2, never less than 1 so counters always have at least one bit.
   function automatic int unsigned CLOG2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'(1) << i) < 64'(value)) begin
            result = i + 1;
         end
      end
      if (result == 0) begin
         result = 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/control_decoder_n_debounce_bit.sv
// One switch bit: synchroniser chain, debounce counter and accepted (stable) level.
module debounce_bit
   import control_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter logic        RESET_BIT       = 1'b0
) (
   input  logic clk_div,
   input  logic rst_n,
   input  logic sw,
   output logic stable
);

   localparam int unsigned CNT_W = CLOG2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_c;
   logic                   stable_c;
   logic                   sync_out;

   assign sync_out = sync_q[SYNC_STAGES-1];

   // Debounce decision: accept a new level only after it persists long enough.
   always_comb begin
      cnt_c    = '0;
      stable_c = stable;
      if (sync_out != stable) begin
         if (cnt_q == CNT_LAST) begin
            stable_c = sync_out;
         end else begin
            cnt_c = cnt_q + CNT_W'(1);
         end
      end
   end

   // Synchroniser shift, counter and stable level registers.
   always_ff @(posedge clk_div or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {SYNC_STAGES{RESET_BIT}};
         cnt_q  <= '0;
         stable <= RESET_BIT;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
         cnt_q  <= cnt_c;
         stable <= stable_c;
      end
   end

endmodule

// File: rtl/control_decoder_n.sv
// Switch control decoder: per-bit sync/debounce, hold-able control word, change strobe.
module control_decoder_n
   import control_pkg::*;
#(
   parameter int unsigned           WIDTH           = DEF_WIDTH,
   parameter int unsigned           SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int unsigned           DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter logic [WIDTH-1:0]      RESET_VALUE     = WIDTH'(CTRL_RESET_VALUE)
) (
   input  logic             clk_div,
   input  logic             BTN0,
   input  logic [WIDTH-1:0] SW,
   input  logic             hold,
   output logic [WIDTH-1:0] ctrl_word,
   output logic             ctrl_valid,
   output logic [WIDTH-1:0] changed_mask
);

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] load_c;
   logic [WIDTH-1:0] diff_c;

   // Independent debouncer per bit so bits settle separately.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_BIT       (RESET_VALUE[i])
      ) u_debounce (
         .clk_div (clk_div),
         .rst_n   (BTN0),
         .sw      (SW[i]),
         .stable  (stable[i])
      );
   end

   // Hold mux and change detect against the current control word.
   always_comb begin
      load_c = ctrl_word;
      if (!hold) begin
         load_c = stable;
      end
      diff_c = ctrl_word ^ load_c;
   end

   // Control word and single-cycle change strobe registers.
   always_ff @(posedge clk_div or negedge BTN0) begin
      if (!BTN0) begin
         ctrl_word    <= RESET_VALUE;
         ctrl_valid   <= 1'b0;
         changed_mask <= '0;
      end else begin
         ctrl_word    <= load_c;
         ctrl_valid   <= |diff_c;
         changed_mask <= diff_c;
      end
   end

endmodule

// File: tb/tb_control_decoder_n.sv
// Self-checking bench: directed table, hand sequences and randomized model comparison.
module tb_control_decoder_n;
   import control_pkg::*;

   localparam int unsigned W = 4;
   localparam int unsigned S = 2;
   localparam int unsigned D = 4;
   localparam logic [W-1:0] RV = W'(CTRL_RESET_VALUE);

   logic         clk_div;
   logic         BTN0;
   logic [W-1:0] SW;
   logic         hold;
   logic [W-1:0] ctrl_word;
   logic         ctrl_valid;
   logic [W-1:0] changed_mask;

   int unsigned n_cmp;
   int unsigned n_bad;

   control_decoder_n #(
      .WIDTH           (W),
      .SYNC_STAGES     (S),
      .DEBOUNCE_CYCLES (D),
      .RESET_VALUE     (RV)
   ) dut (
      .clk_div      (clk_div),
      .BTN0         (BTN0),
      .SW           (SW),
      .hold         (hold),
      .ctrl_word    (ctrl_word),
      .ctrl_valid   (ctrl_valid),
      .changed_mask (changed_mask)
   );

   initial clk_div = 1'b0;
   always #5 clk_div = ~clk_div;

   // Reference model: delayed samples, a history window of synchronised samples,
   // and the visible control word.
   logic [W-1:0] m_delay[$];
   logic [W-1:0] m_window[$];
   logic [W-1:0] m_stable;
   logic [W-1:0] m_ctrl;
   logic         m_valid;
   logic [W-1:0] m_mask;

   function automatic void model_reset();
      m_delay.delete();
      m_window.delete();
      for (int k = 0; k < int'(S); k++) m_delay.push_back(RV);
      for (int k = 0; k < int'(D); k++) m_window.push_back(RV);
      m_stable = RV;
      m_ctrl   = RV;
      m_valid  = 1'b0;
      m_mask   = '0;
   endfunction

   // One rising edge: the word loads the previously accepted level, then a bit is
   // accepted when its last D synchronised samples all disagree with the accepted level.
   function automatic void model_edge(input logic [W-1:0] sw_in, input logic hold_in);
      logic [W-1:0] synced;
      logic [W-1:0] nxt;
      synced = m_delay.pop_back();
      m_delay.push_front(sw_in);
      nxt     = hold_in ? m_ctrl : m_stable;
      m_mask  = m_ctrl ^ nxt;
      m_valid = (m_mask != '0);
      m_ctrl  = nxt;
      void'(m_window.pop_back());
      m_window.push_front(synced);
      for (int i = 0; i < int'(W); i++) begin
         int agree;
         agree = 0;
         for (int k = 0; k < int'(D); k++) begin
            if (m_window[k][i] == m_stable[i]) agree++;
         end
         if (agree == 0) m_stable[i] = ~m_stable[i];
      end
   endfunction

   task automatic check(input string name, input logic [2*W:0] exp);
      logic [2*W:0] act;
      act = {ctrl_word, ctrl_valid, changed_mask};
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got word=%b valid=%b mask=%b, want word=%b valid=%b mask=%b",
                  name, act[2*W:W+1], act[W], act[W-1:0], exp[2*W:W+1], exp[W], exp[W-1:0]);
      end
   endtask

   // Advance one clock, update the model, compare at the falling edge.
   task automatic step();
      @(posedge clk_div);
      if (BTN0) model_edge(SW, hold);
      @(negedge clk_div);
      check("model", {m_ctrl, m_valid, m_mask});
   endtask

   typedef struct {
      logic [W-1:0] sw;
      logic         hold;
      int unsigned  cycles;
      logic [W-1:0] exp_word;
      logic         exp_valid;
      logic [W-1:0] exp_mask;
      string        name;
   } vec_t;

   vec_t tbl[$];

   initial begin
      n_cmp = 0;
      n_bad = 0;
      BTN0  = 1'b0;
      SW    = 4'b1111;
      hold  = 1'b0;
      model_reset();

      tbl.push_back('{4'b0000, 1'b0, 7,  4'b0000, 1'b1, 4'b1111, "clear_to_zero"});
      tbl.push_back('{4'b0000, 1'b0, 1,  4'b0000, 1'b0, 4'b0000, "clear_pulse_end"});
      tbl.push_back('{4'b0000, 1'b0, 10, 4'b0000, 1'b0, 4'b0000, "idle"});
      tbl.push_back('{4'b0101, 1'b0, 6,  4'b0000, 1'b0, 4'b0000, "lat_edge6"});
      tbl.push_back('{4'b0101, 1'b0, 1,  4'b0101, 1'b1, 4'b0101, "lat_edge7"});
      tbl.push_back('{4'b0101, 1'b0, 1,  4'b0101, 1'b0, 4'b0000, "lat_pulse_end"});
      tbl.push_back('{4'b0101, 1'b0, 10, 4'b0101, 1'b0, 4'b0000, "lat_no_more"});
      tbl.push_back('{4'b1101, 1'b0, 3,  4'b0101, 1'b0, 4'b0000, "glitch3_high"});
      tbl.push_back('{4'b0101, 1'b0, 10, 4'b0101, 1'b0, 4'b0000, "glitch3_reject"});
      tbl.push_back('{4'b1101, 1'b0, 4,  4'b0101, 1'b0, 4'b0000, "glitch4_high"});
      tbl.push_back('{4'b0101, 1'b0, 3,  4'b1101, 1'b1, 4'b1000, "glitch4_accept"});
      tbl.push_back('{4'b0101, 1'b0, 4,  4'b0101, 1'b1, 4'b1000, "glitch4_fall"});
      tbl.push_back('{4'b0101, 1'b0, 1,  4'b0101, 1'b0, 4'b0000, "glitch4_settle"});
      tbl.push_back('{4'b1010, 1'b1, 20, 4'b0101, 1'b0, 4'b0000, "hold_frozen"});
      tbl.push_back('{4'b1010, 1'b0, 1,  4'b1010, 1'b1, 4'b1111, "hold_release"});
      tbl.push_back('{4'b1010, 1'b0, 1,  4'b1010, 1'b0, 4'b0000, "hold_single"});
      tbl.push_back('{4'b0000, 1'b0, 7,  4'b0000, 1'b1, 4'b1010, "stag_clear"});
      tbl.push_back('{4'b0000, 1'b0, 1,  4'b0000, 1'b0, 4'b0000, "stag_idle"});
      tbl.push_back('{4'b0001, 1'b0, 2,  4'b0000, 1'b0, 4'b0000, "stag_bit0"});
      tbl.push_back('{4'b0011, 1'b0, 5,  4'b0001, 1'b1, 4'b0001, "stag_pulse0"});
      tbl.push_back('{4'b0011, 1'b0, 1,  4'b0001, 1'b0, 4'b0000, "stag_gap"});
      tbl.push_back('{4'b0011, 1'b0, 1,  4'b0011, 1'b1, 4'b0010, "stag_pulse1"});
      tbl.push_back('{4'b0011, 1'b0, 1,  4'b0011, 1'b0, 4'b0000, "stag_end"});

      // Reset held with all switches high: outputs stay at reset values.
      @(negedge clk_div);
      check("reset_now", {RV, 1'b0, 4'b0000});
      repeat (3) step();
      check("reset_held", {RV, 1'b0, 4'b0000});
      BTN0 = 1'b1;
      repeat (6) step();
      check("rel_edge6", {RV, 1'b0, 4'b0000});
      step();
      check("rel_edge7", {4'b1111, 1'b1, 4'b1111});
      step();
      check("rel_pulse_end", {4'b1111, 1'b0, 4'b0000});

      // Directed table.
      foreach (tbl[v]) begin
         SW   = tbl[v].sw;
         hold = tbl[v].hold;
         for (int unsigned c = 0; c < tbl[v].cycles; c++) step();
         check(tbl[v].name, {tbl[v].exp_word, tbl[v].exp_valid, tbl[v].exp_mask});
      end

      // Reset in the middle of a debounce discards all progress.
      SW = 4'b1100;
      repeat (3) step();
      #1;
      BTN0 = 1'b0;
      model_reset();
      #1;
      check("midrst_now", {RV, 1'b0, 4'b0000});
      @(negedge clk_div);
      repeat (2) step();
      check("midrst_held", {RV, 1'b0, 4'b0000});
      BTN0 = 1'b1;
      repeat (6) step();
      check("midrst_edge6", {RV, 1'b0, 4'b0000});
      step();
      check("midrst_edge7", {4'b1100, 1'b1, 4'b1100});

      // Randomized stimulus against the model.
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < int'(W); i++) begin
            if ($urandom_range(0, 7) == 0) SW[i] = ~SW[i];
         end
         if ($urandom_range(0, 24) == 0) hold = ~hold;
         if ($urandom_range(0, 299) == 0) begin
            BTN0 = 1'b0;
            model_reset();
            #1;
            check("rand_reset", {RV, 1'b0, 4'b0000});
            step();
            BTN0 = 1'b1;
         end
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
